// File: rtl/fpu_tag_pkg.sv
// Shared types for the FPU tag table: fflags layout, metadata record, ISA field widths.
package fpu_tag_pkg;
  localparam int FFLAGS_BITS   = 5;
  localparam int INST_FPU_BITS = 4;
  localparam int INST_MOD_BITS = 3;

  localparam int META_WID_BITS    = 2;
  localparam int META_PC_BITS     = 32;
  localparam int META_RD_BITS     = 5;
  localparam int META_NUM_THREADS = 4;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic [META_WID_BITS-1:0]    wid;
    logic [META_PC_BITS-1:0]     pc;
    logic [META_RD_BITS-1:0]     rd;
    logic [META_NUM_THREADS-1:0] tmask;
  } fpu_tag_meta_t;
endpackage

// File: rtl/vx_fpu_tag_alloc.sv
// Free-tag bitmap with lowest-index allocation and in-flight counter.
module vx_fpu_tag_alloc #(
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc_en,
  input  logic            free_en,
  input  logic [TAGW-1:0] free_tag,
  output logic [TAGW-1:0] alloc_tag,
  output logic            full,
  output logic [TAGW:0]   pending
);
  localparam int DEPTH = 2**TAGW;

  logic [DEPTH-1:0] busy;

  always_comb begin
    alloc_tag = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!busy[i]) alloc_tag = TAGW'(i);
  end

  assign full = &busy;

  // Alloc and free never hit the same entry: alloc_tag is free, free_tag is busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= '0;
      pending <= '0;
    end else begin
      if (free_en)  busy[free_tag]  <= 1'b0;
      if (alloc_en) busy[alloc_tag] <= 1'b1;
      pending <= pending + {{TAGW{1'b0}}, alloc_en} - {{TAGW{1'b0}}, free_en};
    end
  end

  a_free_busy: assert property (@(posedge clk) disable iff (!reset) free_en |-> busy[free_tag]);
  a_no_full:   assert property (@(posedge clk) disable iff (!reset) alloc_en |-> !full);
endmodule

// File: rtl/vx_fpu_tag_table.sv
// FPU tag table: tags outgoing requests, restores metadata on return, registers the commit packet.
// Optional perf counters under `FPU_TAG_PERF_EN.
module vx_fpu_tag_table import fpu_tag_pkg::*; #(
  parameter int TAGW        = 4,
  parameter int NUM_THREADS = 4,
  parameter int WID_BITS    = 2,
  parameter int RD_BITS     = 5,
  parameter int PC_BITS     = 32
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic [WID_BITS-1:0]                     req_wid,
  input  logic [PC_BITS-1:0]                      req_pc,
  input  logic [RD_BITS-1:0]                      req_rd,
  input  logic [NUM_THREADS-1:0]                  req_tmask,
  input  logic [INST_FPU_BITS-1:0]                req_op_type,
  input  logic [INST_MOD_BITS-1:0]                req_frm,
  input  logic [NUM_THREADS-1:0][31:0]            req_dataa,
  input  logic [NUM_THREADS-1:0][31:0]            req_datab,
  input  logic [NUM_THREADS-1:0][31:0]            req_datac,
  output logic                                    fpu_valid,
  input  logic                                    fpu_ready,
  output logic [TAGW-1:0]                         fpu_tag,
  output logic [INST_FPU_BITS-1:0]                fpu_op_type,
  output logic [INST_MOD_BITS-1:0]                fpu_frm,
  output logic [NUM_THREADS-1:0][31:0]            fpu_dataa,
  output logic [NUM_THREADS-1:0][31:0]            fpu_datab,
  output logic [NUM_THREADS-1:0][31:0]            fpu_datac,
  input  logic                                    rsp_valid,
  output logic                                    rsp_ready,
  input  logic [TAGW-1:0]                         rsp_tag,
  input  logic [NUM_THREADS-1:0][31:0]            rsp_result,
  input  logic                                    rsp_has_fflags,
  input  logic [NUM_THREADS-1:0][FFLAGS_BITS-1:0] rsp_fflags,
  output logic                                    cmt_valid,
  input  logic                                    cmt_ready,
  output logic [WID_BITS-1:0]                     cmt_wid,
  output logic [PC_BITS-1:0]                      cmt_pc,
  output logic [RD_BITS-1:0]                      cmt_rd,
  output logic [NUM_THREADS-1:0]                  cmt_tmask,
  output logic [NUM_THREADS-1:0][31:0]            cmt_data,
  output logic                                    cmt_has_fflags,
  output logic [FFLAGS_BITS-1:0]                  cmt_fflags,
  output logic [TAGW:0]                           pending,
  output logic                                    empty
`ifdef FPU_TAG_PERF_EN
  ,
  output logic [31:0]                             perf_full_stalls,
  output logic [31:0]                             perf_cmt_stalls
`endif
);
  localparam int DEPTH = 2**TAGW;

  typedef struct packed {
    logic [WID_BITS-1:0]    wid;
    logic [PC_BITS-1:0]     pc;
    logic [RD_BITS-1:0]     rd;
    logic [NUM_THREADS-1:0] tmask;
  } meta_t;

  logic  full, req_fire, rsp_fire;
  meta_t meta_mem [DEPTH];
  meta_t rd_meta;
  logic  [NUM_THREADS-1:0][FFLAGS_BITS-1:0] lane_ff;
  fflags_t ff_red;

  vx_fpu_tag_alloc #(.TAGW(TAGW)) u_alloc (
    .clk       (clk),
    .reset     (reset),
    .alloc_en  (req_fire),
    .free_en   (rsp_fire),
    .free_tag  (rsp_tag),
    .alloc_tag (fpu_tag),
    .full      (full),
    .pending   (pending)
  );

  assign fpu_valid   = req_valid && !full;
  assign req_ready   = fpu_ready && !full;
  assign req_fire    = req_valid && req_ready;
  assign fpu_op_type = req_op_type;
  assign fpu_frm     = req_frm;
  assign fpu_dataa   = req_dataa;
  assign fpu_datab   = req_datab;
  assign fpu_datac   = req_datac;
  assign empty       = (pending == '0);

  always_ff @(posedge clk)
    if (req_fire) meta_mem[fpu_tag] <= {req_wid, req_pc, req_rd, req_tmask};

  assign rd_meta   = meta_mem[rsp_tag];
  assign rsp_ready = !cmt_valid || cmt_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  // Inactive lanes may carry stale flags from the FPU; mask them before the OR.
  for (genvar l = 0; l < NUM_THREADS; l++) begin : g_lane
    assign lane_ff[l] = rd_meta.tmask[l] ? rsp_fflags[l] : '0;
  end

  always_comb begin
    ff_red = '0;
    for (int l = 0; l < NUM_THREADS; l++) ff_red = ff_red | lane_ff[l];
    if (!rsp_has_fflags) ff_red = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmt_valid      <= 1'b0;
      cmt_wid        <= '0;
      cmt_pc         <= '0;
      cmt_rd         <= '0;
      cmt_tmask      <= '0;
      cmt_data       <= '0;
      cmt_has_fflags <= 1'b0;
      cmt_fflags     <= '0;
    end else if (rsp_fire) begin
      cmt_valid      <= 1'b1;
      cmt_wid        <= rd_meta.wid;
      cmt_pc         <= rd_meta.pc;
      cmt_rd         <= rd_meta.rd;
      cmt_tmask      <= rd_meta.tmask;
      cmt_data       <= rsp_result;
      cmt_has_fflags <= rsp_has_fflags;
      cmt_fflags     <= ff_red;
    end else if (cmt_ready) begin
      cmt_valid      <= 1'b0;
    end
  end

`ifdef FPU_TAG_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_full_stalls <= '0;
      perf_cmt_stalls  <= '0;
    end else begin
      if (req_valid && full)      perf_full_stalls <= perf_full_stalls + 32'd1;
      if (cmt_valid && !cmt_ready) perf_cmt_stalls  <= perf_cmt_stalls + 32'd1;
    end
  end
`endif

  a_cmt_stable: assert property (@(posedge clk) disable iff (!reset)
    cmt_valid && !cmt_ready |=> cmt_valid &&
      $stable({cmt_wid, cmt_pc, cmt_rd, cmt_tmask, cmt_data, cmt_has_fflags, cmt_fflags}));
endmodule
